// File: rtl/rtc_pkg.sv
// Shared constants, state encoding and digit helper for the RTC BCD field scheduler.
package rtc_pkg;

    localparam int unsigned FLD_SEC    = 0;
    localparam int unsigned FLD_MIN    = 1;
    localparam int unsigned FLD_HOUR   = 2;
    localparam int unsigned FLD_DAY    = 3;
    localparam int unsigned FLD_MONTH  = 4;
    localparam int unsigned FLD_YEAR   = 5;
    localparam int unsigned NUM_FIELDS = 6;

    localparam int unsigned BCD_W = 8;
    // Engine holds hundreds/tens/units digits.
    localparam int unsigned ENG_W = 12;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StStore,
        StDone
    } state_e;

    // Double-dabble correction: a digit of 5 or more would overflow after the shift.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/dd_serial_engine.sv
// Serial double-dabble converter: one input bit per step, MSB first, into a 3-digit BCD register.
module dd_serial_engine
    import rtc_pkg::*;
#(
    // The 3-bit step counter limits this to at most 8 bits.
    parameter int unsigned BIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [BIN_W-1:0] bin,
    output logic [ENG_W-1:0] bcd,
    output logic             last_step
);

    logic [ENG_W-1:0] bcd_q;
    logic [ENG_W-1:0] adj;
    logic [ENG_W-1:0] bcd_d;
    logic [BIN_W-1:0] bin_q;
    logic [2:0]       cnt_q;

    // Correct every digit, then shift left pulling in the next binary bit.
    always_comb begin
        adj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        bcd_d = 12'({adj, bin_q[BIN_W-1]});
    end

    // Shift register, pending binary bits and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            bcd_q <= '0;
            bin_q <= bin;
            cnt_q <= '0;
        end else if (step) begin
            bcd_q <= bcd_d;
            bin_q <= {bin_q[BIN_W-2:0], 1'b0};
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign bcd       = bcd_q;
    assign last_step = step && (cnt_q == 3'(BIN_W - 1));

endmodule

// File: rtl/bcd_field_scheduler.sv
// Converts six RTC fields to packed BCD through one shared serial engine and commits all at once.
module bcd_field_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned BIN_W      = 8,
    parameter bit          SAT_ON_OVF = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] sec,
    input  logic [BIN_W-1:0] min,
    input  logic [BIN_W-1:0] hour,
    input  logic [BIN_W-1:0] days,
    input  logic [BIN_W-1:0] months,
    input  logic [BIN_W-1:0] years,
    output logic [BCD_W-1:0] sec_bcd,
    output logic [BCD_W-1:0] min_bcd,
    output logic [BCD_W-1:0] hour_bcd,
    output logic [BCD_W-1:0] days_bcd,
    output logic [BCD_W-1:0] months_bcd,
    output logic [BCD_W-1:0] years_bcd,
    output logic [5:0]       ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned LAST_IDX = NUM_FIELDS - 1;

    state_e state_q, state_d;

    logic [BIN_W-1:0] fld_in    [NUM_FIELDS];
    logic [BIN_W-1:0] snap_q    [NUM_FIELDS];
    logic [BCD_W-1:0] shadow_q  [NUM_FIELDS];
    logic [BCD_W-1:0] out_q     [NUM_FIELDS];
    logic [5:0]       ovf_shadow_q;
    logic [5:0]       ovf_q;
    logic [2:0]       idx_q;
    logic             pending_q;
    logic             done_q;

    logic             snap_en;
    logic             eng_load;
    logic             eng_step;
    logic             store_en;
    logic             commit_en;
    logic             restart;

    logic [ENG_W-1:0] eng_bcd;
    logic             eng_last;
    logic             hund_nz;
    logic [BCD_W-1:0] store_val;

    assign fld_in[FLD_SEC]   = sec;
    assign fld_in[FLD_MIN]   = min;
    assign fld_in[FLD_HOUR]  = hour;
    assign fld_in[FLD_DAY]   = days;
    assign fld_in[FLD_MONTH] = months;
    assign fld_in[FLD_YEAR]  = years;

    // A start seen during DONE merges with any pending request into one restart.
    assign restart = pending_q || start;

    dd_serial_engine #(
        .BIN_W(BIN_W)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (eng_load),
        .step     (eng_step),
        .bin      (snap_q[idx_q]),
        .bcd      (eng_bcd),
        .last_step(eng_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (eng_last) state_d = StStore;
            StStore: state_d = (idx_q == 3'(LAST_IDX)) ? StDone : StLoad;
            StDone:  state_d = restart ? StLoad : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        snap_en   = 1'b0;
        eng_load  = 1'b0;
        eng_step  = 1'b0;
        store_en  = 1'b0;
        commit_en = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy    = 1'b0;
                snap_en = start;
            end
            StLoad:  eng_load = 1'b1;
            StShift: eng_step = 1'b1;
            StStore: store_en = 1'b1;
            StDone: begin
                commit_en = 1'b1;
                snap_en   = restart;
            end
            default: busy = 1'b0;
        endcase
    end

    // Overflow handling on the finished engine result.
    always_comb begin
        hund_nz   = (eng_bcd[11:8] != 4'd0);
        store_val = (hund_nz && SAT_ON_OVF) ? 8'h99 : eng_bcd[7:0];
    end

    // Snapshot, shadow results, pending request and committed outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FIELDS; k++) begin
                snap_q[k]   <= '0;
                shadow_q[k] <= '0;
                out_q[k]    <= '0;
            end
            ovf_shadow_q <= '0;
            ovf_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= commit_en;

            if (state_q == StDone) begin
                pending_q <= 1'b0;
            end else if (busy && start) begin
                pending_q <= 1'b1;
            end

            if (snap_en) begin
                for (int k = 0; k < NUM_FIELDS; k++) begin
                    snap_q[k] <= fld_in[k];
                end
                idx_q <= '0;
            end else if (store_en && (idx_q != 3'(LAST_IDX))) begin
                idx_q <= idx_q + 3'd1;
            end

            if (store_en) begin
                shadow_q[idx_q]     <= store_val;
                ovf_shadow_q[idx_q] <= hund_nz;
            end

            if (commit_en) begin
                for (int k = 0; k < NUM_FIELDS; k++) begin
                    out_q[k] <= shadow_q[k];
                end
                ovf_q <= ovf_shadow_q;
            end
        end
    end

    assign sec_bcd    = out_q[FLD_SEC];
    assign min_bcd    = out_q[FLD_MIN];
    assign hour_bcd   = out_q[FLD_HOUR];
    assign days_bcd   = out_q[FLD_DAY];
    assign months_bcd = out_q[FLD_MONTH];
    assign years_bcd  = out_q[FLD_YEAR];
    assign ovf        = ovf_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bcd_field_scheduler.sv
// Directed bench for bcd_field_scheduler; one instance per overflow mode, scoreboard on commit.
module tb_bcd_field_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] sec, min, hour, days, months, years;

    logic [7:0] sec_bcd0, min_bcd0, hour_bcd0, days_bcd0, months_bcd0, years_bcd0;
    logic [7:0] sec_bcd1, min_bcd1, hour_bcd1, days_bcd1, months_bcd1, years_bcd1;
    logic [5:0] ovf0, ovf1;
    logic       busy0, busy1, done0, done1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [47:0] b0;
        logic [47:0] b1;
        logic [5:0]  ovf;
    } exp_t;

    exp_t sb[$];

    bcd_field_scheduler #(.BIN_W(8), .SAT_ON_OVF(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sec(sec), .min(min), .hour(hour), .days(days), .months(months), .years(years),
        .sec_bcd(sec_bcd0), .min_bcd(min_bcd0), .hour_bcd(hour_bcd0), .days_bcd(days_bcd0),
        .months_bcd(months_bcd0), .years_bcd(years_bcd0),
        .ovf(ovf0), .busy(busy0), .done(done0)
    );

    bcd_field_scheduler #(.BIN_W(8), .SAT_ON_OVF(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sec(sec), .min(min), .hour(hour), .days(days), .months(months), .years(years),
        .sec_bcd(sec_bcd1), .min_bcd(min_bcd1), .hour_bcd(hour_bcd1), .days_bcd(days_bcd1),
        .months_bcd(months_bcd1), .years_bcd(years_bcd1),
        .ovf(ovf1), .busy(busy1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] to_bcd(input int v, input bit sat);
        logic [3:0] t, u;
        if (sat && v > 99) return 8'h99;
        v = v % 100;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic logic [47:0] obs_vec0();
        return {years_bcd0, months_bcd0, days_bcd0, hour_bcd0, min_bcd0, sec_bcd0};
    endfunction

    function automatic logic [47:0] obs_vec1();
        return {years_bcd1, months_bcd1, days_bcd1, hour_bcd1, min_bcd1, sec_bcd1};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_inputs(input int a, input int b, input int c, input int d, input int e,
                              input int f);
        sec = 8'(a); min = 8'(b); hour = 8'(c); days = 8'(d); months = 8'(e); years = 8'(f);
    endtask

    task automatic push_expected();
        exp_t e;
        int   v [6];
        v = '{int'(sec), int'(min), int'(hour), int'(days), int'(months), int'(years)};
        for (int k = 0; k < 6; k++) begin
            e.b0[8*k +: 8] = to_bcd(v[k], 1'b0);
            e.b1[8*k +: 8] = to_bcd(v[k], 1'b1);
            e.ovf[k]       = (v[k] > 99);
        end
        sb.push_back(e);
    endtask

    task automatic check_commit();
        exp_t e;
        logic [47:0] o0, o1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed=commit expected=no_commit");
            return;
        end
        e  = sb.pop_front();
        o0 = obs_vec0();
        o1 = obs_vec1();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bcd_sat0_f%0d", k), 48'(o0[8*k +: 8]), 48'(e.b0[8*k +: 8]));
            chk($sformatf("bcd_sat1_f%0d", k), 48'(o1[8*k +: 8]), 48'(e.b1[8*k +: 8]));
        end
        chk("ovf_sat0", 48'(ovf0), 48'(e.ovf));
        chk("ovf_sat1", 48'(ovf1), 48'(e.ovf));
        chk("done_match", 48'(done1), 48'(done0));
    endtask

    // Leaves the bench at the falling edge just after the edge that samples start.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Single run: expect done exactly 61 cycles after the sampling edge.
    task automatic run_one(input string tag);
        int n;
        push_expected();
        kick();
        n = 0;
        while (!done0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed=no_done expected=done", tag);
            sb.delete();
        end else begin
            chk({tag, "_latency"}, 48'(n), 48'd61);
            check_commit();
        end
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0);

        // Reset state.
        #1;
        chk("rst_bcd0", obs_vec0(), 48'h0);
        chk("rst_bcd1", obs_vec1(), 48'h0);
        chk("rst_ovf", 48'({ovf1, ovf0}), 48'h0);
        chk("rst_busy_done", 48'({busy1, busy0, done1, done0}), 48'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done0 || done1) dones++;
        end
        chk("idle_no_done", 48'(dones), 48'd0);
        chk("idle_busy", 48'({busy1, busy0}), 48'h0);

        // Basic conversion with full cycle-level timing.
        set_inputs(59, 7, 23, 31, 12, 99);
        push_expected();
        kick();
        for (int n = 0; n <= 61; n++) begin
            chk($sformatf("basic_busy_n%0d", n), 48'(busy0), 48'(n < 61));
            chk($sformatf("basic_done_n%0d", n), 48'(done0), 48'(n == 61));
            if (n < 61) chk($sformatf("basic_hold_n%0d", n), obs_vec0(), 48'h0);
            else check_commit();
            if (n < 61) @(negedge clk);
        end

        // Overflow cases.
        set_inputs(59, 7, 23, 31, 12, 255);
        run_one("ovf255");
        set_inputs(59, 7, 23, 31, 12, 100);
        run_one("ovf100");

        // Boundary values.
        set_inputs(0, 9, 10, 99, 10, 0);
        run_one("bound");

        // Pending: extra starts while busy collapse into one follow-up run.
        set_inputs(59, 7, 23, 31, 12, 99);
        push_expected();
        kick();
        dones = 0;
        for (int n = 0; n <= 130; n++) begin
            chk($sformatf("pend_busy_n%0d", n), 48'(busy0), 48'(n < 122));
            chk($sformatf("pend_done_n%0d", n), 48'(done0), 48'(n == 61 || n == 122));
            if (done0) begin
                dones++;
                check_commit();
            end
            if (n == 24) begin
                sec = 8'd0;
                push_expected();
            end
            start = (n == 19 || n == 29);
            @(negedge clk);
        end
        chk("pend_done_count", 48'(dones), 48'd2);

        // Reset in the middle of a run.
        set_inputs(59, 7, 23, 31, 12, 99);
        run_one("pre_abort");
        sec = 8'd0;
        push_expected();
        kick();
        repeat (34) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_bcd0", obs_vec0(), 48'h0);
        chk("abort_bcd1", obs_vec1(), 48'h0);
        chk("abort_busy_done", 48'({busy1, busy0, done1, done0}), 48'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (done0 || done1) dones++;
        end
        chk("abort_no_done", 48'(dones), 48'd0);
        set_inputs(42, 7, 23, 31, 12, 99);
        run_one("post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_field_scheduler.md
Name: bcd_field_scheduler

Overview:
- Converts the six RTC time fields (sec, min, hour, days, months, years) from binary to two-digit packed BCD.
- Uses one shared, iterative double-dabble engine instead of six parallel converters.
- On a start request it snapshots all six fields, converts them one after another, then commits all six results in the same cycle, so the display never shows a mix of old and new fields.
- Sits between the RTC counter block and the display/readout logic.

Parameters:
- BIN_W, 8, width of each binary field input. The engine's shift register is 12 bits (3 BCD digits).
- SAT_ON_OVF, 0, controls the output for values above 99. 0: output the low two BCD digits (hundreds digit dropped). 1: output 8'h99.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  conversion request, sampled each rising edge
- sec, min, hour, days, months, years  in  BIN_W each  binary field values
- sec_bcd, min_bcd, hour_bcd, days_bcd, months_bcd, years_bcd  out  8 each  committed packed BCD (tens in [7:4], units in [3:0])
- ovf  out  6  per-field flag, set when the value is above 99. Bit 0 = sec … bit 5 = years.
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse that coincides with the commit

Behaviour:
- Reset:
  - Clock: one clock, clk. Reset rst_n is asynchronous and active-low.
  - While rst_n is low: all *_bcd outputs 8'h00, ovf 0, busy 0, done 0, pending 0, state IDLE, field index 0.
  - Reset asserted mid-conversion aborts the conversion immediately. Shadow results are discarded and no commit or done is produced.
- States: IDLE, LOAD, SHIFT, STORE, DONE.
- IDLE:
  - If start=1, latch all six inputs into the snapshot registers, set idx=0, go to LOAD.
- LOAD:
  - Clear the engine's 12-bit shift register and load snapshot[idx] into it.
  - Clear the bit counter, go to SHIFT.
- SHIFT (8 cycles, one per input bit):
  - Step 1: any BCD digit ≥5 has 3 added.
  - Step 2: shift left by one, bringing in the next input bit, MSB first.
  - After 8 steps go to STORE.
- STORE:
  - Write the result to shadow[idx] using the overflow rules below.
  - Write ovf_shadow[idx] = (hundreds digit ≠ 0).
  - If idx=5 go to DONE; otherwise increment idx and go to LOAD.
- DONE:
  - Copy all shadow values and ovf_shadow to the outputs; done <= 1 for this one cycle.
  - If pending=1: clear pending, take a fresh snapshot, set idx=0, go to LOAD (busy stays high).
  - If pending=0: go to IDLE.
- Overflow rules (applied in STORE):
  - Hundreds digit = 0: output digits [7:0] unchanged.
  - Hundreds digit ≠ 0, SAT_ON_OVF=0: output digits [7:0] (hundreds dropped).
  - Hundreds digit ≠ 0, SAT_ON_OVF=1: output 8'h99.
- Timing: edge 0 samples start.
  - Field k is loaded at edge 1+10k; its STORE is at edge 10+10k.
  - Commit and done at edge 61; done is high for the cycle after edge 61.
  - busy is high from after edge 0 through edge 61 inclusive.
- start while busy:
  - Sets pending. Any number of requests collapse into one.
  - Inputs are not sampled until the DONE cycle.
  - start in the DONE cycle itself also sets or keeps pending.
- Outputs hold their previous committed values throughout a conversion.
- Input changes during a conversion have no effect on that run.

Decomposition:
- Package rtc_pkg holds:
  - field index constants FLD_SEC=0 … FLD_YEAR=5, NUM_FIELDS=6;
  - BCD_W=8;
  - the state encoding.
- Sub-module dd_serial_engine: 12-bit shift register plus 3-bit bit counter.
  - Inputs: load, step.
  - Outputs: bcd[11:0], last_step.
  - The scheduler FSM, snapshot/shadow storage and commit logic stay in bcd_field_scheduler.

Test Plan:
- Reset: hold rst_n low, then release → all *_bcd 8'h00, ovf 0, busy 0, done 0. No done pulse without a start.
- Basic conversion: inputs 59/7/23/31/12/99, one-cycle start at edge 0 → done at edge 61 only. Outputs 8'h59/8'h07/8'h23/8'h31/8'h12/8'h99, ovf 6'b0. Outputs remain 8'h00 through edge 60.
- Overflow: years=255, SAT_ON_OVF=0 → years_bcd 8'h55, ovf 6'b100000. With SAT_ON_OVF=1 → 8'h99. Same check with years=100 → 8'h00 / 8'h99, ovf[5]=1.
- Pending: start at edges 0, 20 and 30; sec changes 59→0 at edge 25.
  - First done at edge 61 shows sec_bcd 8'h59.
  - A second run starts immediately with busy continuously high.
  - Second done at edge 122 shows 8'h00. Exactly two done pulses in total.
- Reset mid-run: after a committed run showing 8'h59, start a run with sec=0 and assert rst_n low at edge 35 → outputs go to 8'h00 asynchronously, busy 0, no done. After release and a new start, conversion completes normally.
- Boundaries: inputs 0, 9, 10, 99 → 8'h00, 8'h09, 8'h10, 8'h99, ovf 0.
